// File: rtl/adc_spi_scanner.sv
`default_nettype none
// adc_spi_scanner: pipelined multi-channel SPI ADC scanner (ADC128S022-style frames).
// Optional macro ADC_SCAN_AVG_EN makes CH_DATA hold 4-scan averages instead of raw results.
module adc_spi_scanner #(
  parameter int NUM_CH  = 8,
  parameter int DATA_W  = 12,
  parameter int CLK_DIV = 2
) (
  input  logic                     CLOCK,
  input  logic                     RESET,
  input  logic                     ENABLE,
  input  logic                     START,
  input  logic [NUM_CH-1:0]        CH_MASK,
  output logic [NUM_CH*DATA_W-1:0] CH_DATA,
  output logic [DATA_W-1:0]        SAMPLE_DATA,
  output logic [2:0]               SAMPLE_CH,
  output logic                     SAMPLE_VALID,
  output logic                     SCAN_DONE,
  output logic                     BUSY,
  output logic                     ADC_SCLK,
  output logic                     ADC_CS_N,
  output logic                     ADC_DIN,
  input  logic                     ADC_DOUT
);

  localparam int CNT_W = $clog2(2*CLK_DIV+1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_CS_SETUP  = 3'd1;
  localparam logic [2:0] S_SHIFT     = 3'd2;
  localparam logic [2:0] S_FRAME_END = 3'd3;
  localparam logic [2:0] S_QUIET     = 3'd4;

  logic [2:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [3:0]        bit_cnt;
  logic [11:0]       rx;
  logic [NUM_CH-1:0] mask;
  logic [2:0]        cur_addr;
  logic [2:0]        prev_addr;
  logic              first_frame;
  logic              final_frame;
  logic [3:0]        first_ch;
  logic [3:0]        next_ch;
  logic [DATA_W-1:0] payload;
  logic              write_en;

  // Lowest enabled channel at or above lo, as {found, index}.
  function automatic logic [3:0] find_ch(input logic [NUM_CH-1:0] m, input int lo);
    logic [3:0] r;
    r = 4'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (m[i] && i >= lo) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  function automatic logic din_bit(input logic [3:0] k, input logic [2:0] a);
    case (k)
      4'd2:    din_bit = a[2];
      4'd3:    din_bit = a[1];
      4'd4:    din_bit = a[0];
      default: din_bit = 1'b0;
    endcase
  endfunction

  assign first_ch = find_ch(CH_MASK, 0);
  assign next_ch  = find_ch(mask, int'(cur_addr) + 1);
  assign payload  = rx[11 -: DATA_W];
  assign write_en = (state == S_FRAME_END) && !first_frame;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state        <= S_IDLE;
      cnt          <= '0;
      bit_cnt      <= '0;
      rx           <= '0;
      mask         <= '0;
      cur_addr     <= '0;
      prev_addr    <= '0;
      first_frame  <= 1'b0;
      final_frame  <= 1'b0;
      SAMPLE_DATA  <= '0;
      SAMPLE_CH    <= '0;
      SAMPLE_VALID <= 1'b0;
      SCAN_DONE    <= 1'b0;
      BUSY         <= 1'b0;
      ADC_SCLK     <= 1'b1;
      ADC_CS_N     <= 1'b1;
      ADC_DIN      <= 1'b0;
    end else begin
      SAMPLE_VALID <= 1'b0;
      SCAN_DONE    <= 1'b0;
      case (state)
        S_IDLE: begin
          if ((ENABLE || START) && (|CH_MASK)) begin
            mask        <= CH_MASK;
            cur_addr    <= first_ch[2:0];
            first_frame <= 1'b1;
            final_frame <= 1'b0;
            BUSY        <= 1'b1;
            ADC_CS_N    <= 1'b0;
            cnt         <= '0;
            state       <= S_CS_SETUP;
          end
        end
        S_CS_SETUP: begin
          if (cnt == CNT_W'(CLK_DIV - 1)) begin
            cnt      <= '0;
            ADC_SCLK <= 1'b0;
            ADC_DIN  <= 1'b0;
            bit_cnt  <= '0;
            state    <= S_SHIFT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_SHIFT: begin
          if (cnt == CNT_W'(CLK_DIV - 1)) begin
            cnt      <= '0;
            ADC_SCLK <= ~ADC_SCLK;
            if (!ADC_SCLK) begin
              // Rising edge: capture DOUT; the 16th one closes the frame.
              rx <= {rx[10:0], ADC_DOUT};
              if (bit_cnt == 4'd15) state <= S_FRAME_END;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
              ADC_DIN <= din_bit(bit_cnt + 4'd1, cur_addr);
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_FRAME_END: begin
          first_frame <= 1'b0;
          if (!first_frame) begin
            SAMPLE_DATA  <= payload;
            SAMPLE_CH    <= prev_addr;
            SAMPLE_VALID <= 1'b1;
          end
          cnt <= '0;
          if (final_frame) begin
            ADC_CS_N  <= 1'b1;
            SCAN_DONE <= 1'b1;
            state     <= S_QUIET;
          end else begin
            // bit_cnt wraps to 0 on the next falling edge; SCLK is already high.
            prev_addr <= cur_addr;
            if (next_ch[3]) cur_addr <= next_ch[2:0];
            else            final_frame <= 1'b1;
            bit_cnt   <= 4'hF;
            state     <= S_SHIFT;
          end
        end
        S_QUIET: begin
          if (cnt == CNT_W'(2*CLK_DIV - 1)) begin
            BUSY  <= 1'b0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef ADC_SCAN_AVG_EN
  logic [DATA_W+1:0] acc     [NUM_CH];
  logic [1:0]        acc_cnt [NUM_CH];

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      CH_DATA <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        acc[k]     <= '0;
        acc_cnt[k] <= '0;
      end
    end else if (write_en) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (k == int'(prev_addr)) begin
          acc_cnt[k] <= acc_cnt[k] + 2'd1;
          if (acc_cnt[k] == 2'd3) begin
            CH_DATA[k*DATA_W +: DATA_W] <= DATA_W'((acc[k] + (DATA_W+2)'(payload)) >> 2);
            acc[k] <= '0;
          end else begin
            acc[k] <= acc[k] + (DATA_W+2)'(payload);
          end
        end
      end
    end
  end
`else
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      CH_DATA <= '0;
    end else if (write_en) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (k == int'(prev_addr)) CH_DATA[k*DATA_W +: DATA_W] <= payload;
      end
    end
  end
`endif

endmodule
`default_nettype wire
